hazard_fwd_unit: RTL and testbench
==================================

# hazard_fwd_unit

Hazard and forwarding controller for the 5-stage RISC-V pipeline. It is the producer of the `clr_de` input of the decode/execute pipeline register, and it consumes that register's execute-side outputs (`rd_e`, `rs1_e`, `rs2_e`, `regwrite_e`, `resultsrc_e`). It keeps shadow copies of the destination/write-enable for the memory and writeback stages, and from those generates forwarding selects, load-use stalls, control-hazard flushes and saturating event counters.

## Interface
Parameters:
- `CNT_W`, default 16: width of the stall and flush event counters.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous reset, active-high.
- `rs1_d`, `rs2_d`  in  5 each  decode-stage source registers.
- `rs1_e`, `rs2_e`  in  5 each  execute-stage source registers, from the decode/execute register.
- `rd_e`  in  5  execute-stage destination register.
- `regwrite_e`  in  1  execute-stage register-write enable.
- `resultsrc_e`  in  2  execute-stage result select; 2'b01 means load.
- `pcsrc_e`  in  1  taken branch or jump resolved in execute.
- `stall_f`, `stall_d`  out  1 each  hold the PC and the fetch/decode register.
- `flush_d`  out  1  clear the fetch/decode register.
- `clr_de`  out  1  clear the decode/execute register (bubble).
- `forward_a_e`, `forward_b_e`  out  2 each  ALU operand select: 00 = register file, 01 = writeback result, 10 = memory-stage ALU result.
- `stall_count`, `flush_count`  out  CNT_W each  saturating event counters.

## Operation
- Shadow state: each rising edge, `rd_e`/`regwrite_e` → `rd_m`/`regwrite_m`, and `rd_m`/`regwrite_m` → `rd_w`/`regwrite_w`.
  - Execute→memory never stalls.
  - A cleared decode/execute entry arrives with `regwrite_e=0`, so it propagates as a bubble.
- Forward A (B identical, using `rs2_e`):
  - 10 if `regwrite_m` and `rd_m`≠0 and `rd_m`==`rs1_e`.
  - Otherwise 01 if `regwrite_w` and `rd_w`≠0 and `rd_w`==`rs1_e`.
  - Otherwise 00.
  - Memory-stage priority is mandatory.
- `lwstall` = (`resultsrc_e`==2'b01) and `rd_e`≠0 and (`rd_e`==`rs1_d` or `rd_e`==`rs2_d`).
- Outputs:
  - `stall_f` = `stall_d` = `lwstall` and not `pcsrc_e`.
  - `flush_d` = `pcsrc_e`.
  - `clr_de` = `lwstall` or `pcsrc_e`.
- Simultaneous load-use and `pcsrc_e`: redirect wins.
  - No stall.
  - D and E both cleared.
  - Only `flush_count` increments.
- Counters:
  - `stall_count` +1 on each edge where `stall_d`=1.
  - `flush_count` +1 on each edge where `pcsrc_e`=1.
  - Both saturate at 2^CNT_W−1 with no wrap.
- x0 is never a hazard source: `rd`=0 never forwards and never stalls.

## Timing
- Forward, stall, flush and clear outputs are combinational from the current inputs and registered shadow state (same cycle). Counters and shadow state update at the rising edge.
- Forwarding latency: a producer seen in E at cycle n is forwarded from M in cycle n+1 and from W in cycle n+2. At n+3 it is no longer forwarded; the register file supplies it.
- Load-use: exactly one stall cycle per occurrence. The next cycle the load is in M, the shadow `regwrite_m` is set, and the dependent instruction receives forward 01 one cycle later, from W.
- While `rst`=1:
  - `clr_de`=1, `flush_d`=1, `stall_f`=`stall_d`=0, forwards=00.
  - At the edge, shadow `regwrite_m`/`regwrite_w`=0, `rd_m`/`rd_w`=0, counters=0.
  - Reset mid-operation discards all shadow state on that edge; no forwarding occurs in the first cycle after reset.
- First cycle after `rst` deasserts: outputs are derived from the inputs only, with shadow state empty.

## Test plan
- Reset: hold `rst`=1 for 2 cycles with arbitrary inputs → `clr_de`=1, `flush_d`=1, stalls 0, forwards 00, counters 0; the cycle after release has forwards 00.
- ALU chain: E writes x5 (`regwrite_e`=1, `rd_e`=5), next cycle `rs1_e`=5, `rs2_e`=5 → `forward_a_e`=`forward_b_e`=10. With one gap instruction in between → 01. With two gaps → 00.
- M/W priority: x7 written in two consecutive instructions, then `rs2_e`=7 → `forward_b_e`=10 (newer value).
- Load-use: `resultsrc_e`=01, `rd_e`=9, `rs1_d`=9 → `stall_f`=`stall_d`=`clr_de`=1 for exactly 1 cycle and `stall_count`=1. With `rd_e`=0 instead → no stall.
- Redirect collision: `pcsrc_e`=1 with load-use also true → `flush_d`=`clr_de`=1, stalls 0, `flush_count`+1, `stall_count` unchanged.
- Saturation: `CNT_W`=4, hold a load-use pattern for 20 cycles → `stall_count` stops at 15.

Source files
------------

// File: rtl/hazard_fwd_unit.sv
// Hazard and forwarding controller for a 5-stage RISC-V pipeline: shadow M/W
// destination tracking, operand forwarding, load-use stall, redirect flush, event counters.
module hazard_fwd_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_d,
    input  logic [4:0]       rs2_d,
    input  logic [4:0]       rs1_e,
    input  logic [4:0]       rs2_e,
    input  logic [4:0]       rd_e,
    input  logic             regwrite_e,
    input  logic [1:0]       resultsrc_e,
    input  logic             pcsrc_e,
    output logic             stall_f,
    output logic             stall_d,
    output logic             flush_d,
    output logic             clr_de,
    output logic [1:0]       forward_a_e,
    output logic [1:0]       forward_b_e,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [1:0]       FWD_RF  = 2'b00;
    localparam logic [1:0]       FWD_WB  = 2'b01;
    localparam logic [1:0]       FWD_MEM = 2'b10;
    localparam logic [1:0]       RES_LOAD = 2'b01;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [4:0]       rd_m_reg;
    logic [4:0]       rd_w_reg;
    logic             regwrite_m_reg;
    logic             regwrite_w_reg;
    logic [CNT_W-1:0] stall_count_reg;
    logic [CNT_W-1:0] flush_count_reg;
    logic [CNT_W-1:0] stall_count_next;
    logic [CNT_W-1:0] flush_count_next;

    logic             lwstall;
    logic             stall_int;
    logic [4:0]       src_e [2];

    // Shadow pipeline of destination/write-enable; a cleared D/E entry rides along as a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_m_reg       <= 5'd0;
            rd_w_reg       <= 5'd0;
            regwrite_m_reg <= 1'b0;
            regwrite_w_reg <= 1'b0;
        end else begin
            rd_m_reg       <= rd_e;
            rd_w_reg       <= rd_m_reg;
            regwrite_m_reg <= regwrite_e;
            regwrite_w_reg <= regwrite_m_reg;
        end
    end

    assign src_e[0] = rs1_e;
    assign src_e[1] = rs2_e;

    // One forwarding mux per ALU operand; the memory stage holds the newer value and wins.
    for (genvar gi = 0; gi < 2; gi++) begin : gen_fwd
        logic [1:0] fwd_sel;

        always_comb begin
            fwd_sel = FWD_RF;
            if (!rst) begin
                if (regwrite_m_reg && (rd_m_reg != 5'd0) && (rd_m_reg == src_e[gi])) begin
                    fwd_sel = FWD_MEM;
                end else if (regwrite_w_reg && (rd_w_reg != 5'd0) && (rd_w_reg == src_e[gi])) begin
                    fwd_sel = FWD_WB;
                end
            end
        end
    end

    assign forward_a_e = gen_fwd[0].fwd_sel;
    assign forward_b_e = gen_fwd[1].fwd_sel;

    always_comb begin
        lwstall = 1'b0;
        if ((resultsrc_e == RES_LOAD) && (rd_e != 5'd0) &&
            ((rd_e == rs1_d) || (rd_e == rs2_d))) begin
            lwstall = 1'b1;
        end
    end

    // A taken redirect squashes the dependent instruction anyway, so it overrides the stall.
    assign stall_int = lwstall && !pcsrc_e && !rst;

    assign stall_f = stall_int;
    assign stall_d = stall_int;
    assign flush_d = pcsrc_e || rst;
    assign clr_de  = lwstall || pcsrc_e || rst;

    always_comb begin
        stall_count_next = stall_count_reg;
        flush_count_next = flush_count_reg;
        if (stall_int && (stall_count_reg != CNT_MAX)) begin
            stall_count_next = stall_count_reg + 1'b1;
        end
        if (pcsrc_e && (flush_count_reg != CNT_MAX)) begin
            flush_count_next = flush_count_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count_reg <= '0;
            flush_count_reg <= '0;
        end else begin
            stall_count_reg <= stall_count_next;
            flush_count_reg <= flush_count_next;
        end
    end

    assign stall_count = stall_count_reg;
    assign flush_count = flush_count_reg;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Scoreboard bench for hazard_fwd_unit: directed vectors push expected outputs,
// a negedge monitor pops and compares the combinational response.
module tb_hazard_fwd_unit;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       rs1_d, rs2_d, rs1_e, rs2_e, rd_e;
    logic             regwrite_e;
    logic [1:0]       resultsrc_e;
    logic             pcsrc_e;
    logic             stall_f, stall_d, flush_d, clr_de;
    logic [1:0]       forward_a_e, forward_b_e;
    logic [CNT_W-1:0] stall_count, flush_count;

    typedef struct {
        bit       sf;
        bit       sd;
        bit       fd;
        bit       cl;
        bit [1:0] fa;
        bit [1:0] fb;
        int       sc;
        int       fc;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    applied = 0;
    int    miscompares = 0;

    always #5 clk = ~clk;

    hazard_fwd_unit #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
        .regwrite_e(regwrite_e), .resultsrc_e(resultsrc_e), .pcsrc_e(pcsrc_e),
        .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .clr_de(clr_de),
        .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    task automatic vec(input string nm, input bit r,
                       input logic [4:0] r1d, input logic [4:0] r2d,
                       input logic [4:0] r1e, input logic [4:0] r2e, input logic [4:0] rde,
                       input bit rwe, input logic [1:0] rsrc, input bit pc,
                       input bit es, input bit ef, input bit ec,
                       input bit [1:0] efa, input bit [1:0] efb,
                       input int esc, input int efc);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; rs1_d = r1d; rs2_d = r2d; rs1_e = r1e; rs2_e = r2e; rd_e = rde;
        regwrite_e = rwe; resultsrc_e = rsrc; pcsrc_e = pc;
        e.sf = es; e.sd = es; e.fd = ef; e.cl = ec; e.fa = efa; e.fb = efb;
        e.sc = esc; e.fc = efc;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic chk(input string nm, input string field, input int act, input int req);
        if (act != req) begin
            miscompares++;
            $display("FAIL %s.%s actual=%0d required=%0d", nm, field, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            applied++;
            chk(nm, "stall_f",     int'(stall_f),     int'(e.sf));
            chk(nm, "stall_d",     int'(stall_d),     int'(e.sd));
            chk(nm, "flush_d",     int'(flush_d),     int'(e.fd));
            chk(nm, "clr_de",      int'(clr_de),      int'(e.cl));
            chk(nm, "forward_a_e", int'(forward_a_e), int'(e.fa));
            chk(nm, "forward_b_e", int'(forward_b_e), int'(e.fb));
            chk(nm, "stall_count", int'(stall_count), e.sc);
            chk(nm, "flush_count", int'(flush_count), e.fc);
            $display("vec %0d %s: sf=%0b fd=%0b clr=%0b fa=%0d fb=%0d sc=%0d fc=%0d",
                     applied, nm, stall_f, flush_d, clr_de, forward_a_e, forward_b_e,
                     stall_count, flush_count);
        end
    end

    initial begin
        rst = 1'b1; rs1_d = '0; rs2_d = '0; rs1_e = '0; rs2_e = '0; rd_e = '0;
        regwrite_e = 1'b0; resultsrc_e = 2'b00; pcsrc_e = 1'b0;
        repeat (2) @(posedge clk);

        //   name          rst r1d r2d r1e r2e rde rw rsrc  pc  st fl cl fa     fb     sc fc
        vec("reset0",       1,  3,  3,  4,  4,  3, 1, 2'b01, 0, 0, 1, 1, 2'b00, 2'b00, 0, 0);
        vec("reset1",       1,  0,  0,  3,  3,  6, 1, 2'b00, 1, 0, 1, 1, 2'b00, 2'b00, 0, 0);
        vec("post_rst",     0,  0,  0,  6,  6,  0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        vec("alu_prod",     0,  0,  0,  0,  0,  5, 1, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        vec("alu_fwd_m",    0,  0,  0,  5,  5,  0, 0, 2'b00, 0, 0, 0, 0, 2'b10, 2'b10, 0, 0);
        vec("alu_fwd_w",    0,  0,  0,  5,  5,  0, 0, 2'b00, 0, 0, 0, 0, 2'b01, 2'b01, 0, 0);
        vec("alu_fwd_rf",   0,  0,  0,  5,  5,  0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        vec("x0_prod",      0,  0,  0,  0,  0,  0, 1, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        vec("x0_nofwd",     0,  0,  0,  0,  0,  0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        vec("pri_prod1",    0,  0,  0,  0,  0,  7, 1, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        vec("pri_prod2",    0,  0,  0,  0,  0,  7, 1, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        vec("pri_mem",      0,  0,  0,  3,  7,  0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b10, 0, 0);
        vec("a_from_w",     0,  0,  0,  7,  0,  8, 1, 2'b00, 0, 0, 0, 0, 2'b01, 2'b00, 0, 0);
        vec("gap_prod",     0,  0,  0,  0,  0,  9, 1, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        vec("a_m_b_w",      0,  0,  0,  9,  8,  0, 0, 2'b00, 0, 0, 0, 0, 2'b10, 2'b01, 0, 0);
        vec("nowr_prod",    0,  0,  0,  0,  0, 10, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        vec("nowr_nofwd",   0,  0,  0, 10,  0,  0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        vec("lu_stall",     0,  9,  0,  0,  0,  9, 1, 2'b01, 0, 1, 0, 1, 2'b00, 2'b00, 0, 0);
        vec("lu_bubble",    0,  9,  0,  0,  0,  0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0);
        vec("lu_fwd_w",     0,  0,  0,  9,  0,  0, 0, 2'b00, 0, 0, 0, 0, 2'b01, 2'b00, 1, 0);
        vec("lu_x0",        0,  0,  0,  0,  0,  0, 1, 2'b01, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0);
        vec("lu_rs2",       0,  0, 12,  0,  0, 12, 1, 2'b01, 0, 1, 0, 1, 2'b00, 2'b00, 1, 0);
        vec("lu_after",     0,  0,  0,  0,  0,  0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 2, 0);
        vec("collide",      0, 13,  0,  0,  0, 13, 1, 2'b01, 1, 0, 1, 1, 2'b00, 2'b00, 2, 0);
        vec("collide_aft",  0,  0,  0,  0,  0,  0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 2, 1);
        vec("redirect",     0,  0,  0,  0,  0,  0, 0, 2'b00, 1, 0, 1, 1, 2'b00, 2'b00, 2, 1);
        vec("redir_aft",    0,  0,  0,  0,  0,  0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 2, 2);
        for (int k = 0; k < 20; k++) begin
            vec("saturate", 0, 14,  0,  0,  0, 14, 1, 2'b01, 0, 1, 0, 1, 2'b00, 2'b00,
                ((2 + k) > 15) ? 15 : (2 + k), 2);
        end
        vec("sat_hold",     0,  0,  0,  0,  0,  0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 15, 2);
        vec("mid_rst",      1,  0,  0, 14, 14, 14, 1, 2'b00, 0, 0, 1, 1, 2'b00, 2'b00, 15, 2);
        vec("mid_rst_aft",  0,  0,  0, 14, 14,  0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);

        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
